montgomery_setup: RTL
=====================

Name: montgomery_setup

Overview:
- Precompute stage directly upstream of the Montgomery multiplier.
- Takes an odd modulus N and iteratively derives the constants the multiplier consumes:
  - bit_length k (R = 2^k);
  - rrm = R^2 mod N;
  - n_prime = -N^-1 mod R.
- Runs once per modulus change and holds its results stable for the multiplier until the next accepted start.

Parameters:
- DATA_WIDTH, 8: width of modulus and result words.
- BL_WIDTH, $clog2(DATA_WIDTH+1): width of bit_length.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request computation; sampled only in IDLE.
- modulant  input  DATA_WIDTH  modulus N; latched when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  one-cycle pulse when results (or error) are final.
- valid  output  1  results valid; sticky until the next accepted start or reset.
- error  output  1  N is zero or even; sticky like valid.
- bit_length  output  BL_WIDTH  k = index of the MSB of N, plus 1.
- rrm  output  DATA_WIDTH  2^(2k) mod N.
- n_prime  output  DATA_WIDTH  (2^k - N^-1 mod 2^k) mod 2^k.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy, done, valid and error go to 0.
  - bit_length, rrm and n_prime go to 0.
  - Internal counters and accumulators are cleared.
  - Reset mid-computation aborts the computation; no done is produced.
- IDLE:
  - start=1 latches N and goes to CHECK; valid and error clear on the next edge.
  - start while not in IDLE is ignored and does not queue.
- CHECK (1 cycle):
  - If N==0 or N[0]==0: error<=1, go to DONE.
  - Otherwise: register k from a priority encoder, set acc<=1 and cnt<=0, go to R2.
- R2 (exactly 2k cycles):
  - Each cycle: t = acc<<1, held in DATA_WIDTH+1 bits; acc <= (t >= N) ? t-N : t.
  - After 2k iterations, rrm <= acc.
  - acc is always < N, so no overflow is possible.
- NINV (exactly k-1 cycles; 0 cycles when k==1):
  - Starts with y=1 and i=1.
  - Each cycle: p = N*y, 2*DATA_WIDTH bits; if p[i]==1 then y <= y + (1<<i); i++.
  - On exit: n_prime <= (2^k - y) mod 2^k, computed in DATA_WIDTH bits and masked to k bits.
- DONE (1 cycle):
  - done=1.
  - valid=1 if error is 0.
  - Go to IDLE.
  - start is not accepted in this cycle.
- Latency, with start accepted at edge 0:
  - Valid N: done high in cycle 3k+1.
  - Error case: done high in cycle 2.
- Outputs hold their values between computations.
  - On error, bit_length, rrm and n_prime are 0.
- Invariants, checked by assertion:
  - N*n_prime ≡ 2^k-1 (mod 2^k) when valid.
  - rrm < N when valid.

Optional Feature:
- Macro: MONT_SETUP_CACHE_EN.
- When defined, the last successful N is kept in a cache register with a cache-valid flag.
  - A start with modulant equal to the cached N, while the flag is set, goes IDLE -> DONE directly.
  - done pulses in cycle 1; outputs are unchanged and valid is re-asserted.
  - The flag clears on reset and on any error result.
- When undefined:
  - No cache register exists.
  - Every start takes the full latency.

Test Plan:
- Basic: reset, then start with N=13 (DATA_WIDTH=8) -> done in cycle 13; bit_length=4, rrm=9, n_prime=11, valid=1, error=0.
- Full width: N=251 -> done in cycle 25; bit_length=8, rrm=25, n_prime=205; busy high in cycles 1..25.
- Degenerate and error cases:
  - N=1 -> done in cycle 4; bit_length=1, rrm=0, n_prime=1.
  - N=12 -> done in cycle 2; error=1, valid=0, rrm=0.
  - N=0 -> same result as N=12.
- Ignored start: start re-pulsed during R2 for N=13, with modulant changed to 7 -> ignored; results still those of N=13 at cycle 13.
- Reset mid-operation: reset asserted at cycle 6 of N=251 -> next cycle all outputs are 0 and state is IDLE, no done; a following start with N=13 completes normally.
- Cache (MONT_SETUP_CACHE_EN):
  - N=13 then N=13 again -> second done in cycle 1, same outputs.
  - N=13, N=11, N=13 -> third run takes the full 13 cycles.

Source files
------------

// File: rtl/montgomery_setup.sv
// montgomery_setup: derives the Montgomery constants for an odd modulus N.
//   bit_length = k (R = 2^k), rrm = R^2 mod N, n_prime = -N^-1 mod R.
// Iterative: one modular doubling per cycle for rrm, one Hensel-lifting bit
// per cycle for the inverse. Results stay put until the next accepted start.
// Optional build macro MONT_SETUP_CACHE_EN: remembers the last good modulus
// and answers a repeated request in one cycle without recomputing.
module montgomery_setup #(
    parameter int DATA_WIDTH = 8,
    parameter int BL_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic                  error,
    output logic [BL_WIDTH-1:0]   bit_length,
    output logic [DATA_WIDTH-1:0] rrm,
    output logic [DATA_WIDTH-1:0] n_prime
);

    localparam int CNT_WIDTH = BL_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, CHECK, R2, NINV, DONE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] n_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] y;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [BL_WIDTH-1:0]   idx;
    logic [CNT_WIDTH-1:0]  two_k;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] y_next;
    logic                  r2_last;
    logic                  ninv_last;
    logic                  n_bad;
    logic                  cache_hit;

    // Position of the most significant set bit, plus one (0 for N == 0).
    function automatic logic [BL_WIDTH-1:0] msb_len(input logic [DATA_WIDTH-1:0] n);
        logic [BL_WIDTH-1:0] len;
        len = '0;
        for (int b = 0; b < DATA_WIDTH; b++)
            if (n[b]) len = BL_WIDTH'(b + 1);
        return len;
    endfunction

    // acc*2 mod n for acc < n; the doubled value needs one extra bit.
    function automatic logic [DATA_WIDTH-1:0] mod_double(input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] n);
        logic [DATA_WIDTH:0] t;
        t = {a, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        return t[DATA_WIDTH-1:0];
    endfunction

    // One lifting step: make N*y == 1 hold for bit i as well.
    function automatic logic [DATA_WIDTH-1:0] ninv_step(input logic [DATA_WIDTH-1:0] yv,
                                                        input logic [DATA_WIDTH-1:0] n,
                                                        input logic [BL_WIDTH-1:0]   i);
        logic [2*DATA_WIDTH-1:0] p;
        logic [DATA_WIDTH-1:0]   r;
        p = {{DATA_WIDTH{1'b0}}, n} * {{DATA_WIDTH{1'b0}}, yv};
        r = yv;
        if (p[i]) r = yv + (DATA_WIDTH'(1) << i);
        return r;
    endfunction

    // (2^k - y) mod 2^k, i.e. the negation of y kept to k bits.
    function automatic logic [DATA_WIDTH-1:0] neg_mod(input logic [DATA_WIDTH-1:0] yv,
                                                      input logic [BL_WIDTH-1:0]   k);
        logic [DATA_WIDTH:0] m;
        m = ((DATA_WIDTH + 1)'(1) << k) - (DATA_WIDTH + 1)'(1);
        return (DATA_WIDTH'(0) - yv) & m[DATA_WIDTH-1:0];
    endfunction

    assign two_k     = {bit_length, 1'b0};
    assign r2_last   = (cnt == two_k - CNT_WIDTH'(1));
    assign ninv_last = (idx == bit_length - BL_WIDTH'(1));
    assign n_bad     = (n_q == '0) || !n_q[0];
    assign acc_next  = mod_double(acc, n_q);
    assign y_next    = ninv_step(y, n_q, idx);

`ifdef MONT_SETUP_CACHE_EN
    logic [DATA_WIDTH-1:0] cache_n;
    logic                  cache_vld;
    assign cache_hit = cache_vld && (modulant == cache_n);
`else
    assign cache_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and status strobes decoded from the state.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = cache_hit ? DONE : CHECK;
            CHECK:   state_next = n_bad ? DONE : R2;
            R2:      if (r2_last) state_next = (bit_length == BL_WIDTH'(1)) ? DONE : NINV;
            NINV:    if (ninv_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch N, iterate rrm and the inverse, publish results.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= '0;
            acc        <= '0;
            y          <= '0;
            cnt        <= '0;
            idx        <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
            bit_length <= '0;
            rrm        <= '0;
            n_prime    <= '0;
`ifdef MONT_SETUP_CACHE_EN
            cache_n    <= '0;
            cache_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_q   <= modulant;
                    error <= 1'b0;
                    valid <= cache_hit;
                    if (!cache_hit) begin
                        bit_length <= '0;
                        rrm        <= '0;
                        n_prime    <= '0;
                    end
                end
                CHECK: begin
                    if (n_bad) begin
                        error <= 1'b1;
`ifdef MONT_SETUP_CACHE_EN
                        cache_vld <= 1'b0;
`endif
                    end else begin
                        bit_length <= msb_len(n_q);
                        // 1 mod N: for N == 1 the residue is already 0.
                        acc <= (n_q == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
                        cnt <= '0;
                    end
                end
                R2: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (r2_last) begin
                        rrm <= acc_next;
                        y   <= DATA_WIDTH'(1);
                        idx <= BL_WIDTH'(1);
                        if (bit_length == BL_WIDTH'(1)) begin
                            n_prime <= neg_mod(DATA_WIDTH'(1), bit_length);
                            valid   <= 1'b1;
`ifdef MONT_SETUP_CACHE_EN
                            cache_n   <= n_q;
                            cache_vld <= 1'b1;
`endif
                        end
                    end
                end
                NINV: begin
                    y   <= y_next;
                    idx <= idx + BL_WIDTH'(1);
                    if (ninv_last) begin
                        n_prime <= neg_mod(y_next, bit_length);
                        valid   <= 1'b1;
`ifdef MONT_SETUP_CACHE_EN
                        cache_n   <= n_q;
                        cache_vld <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic [DATA_WIDTH-1:0] prod_lo;
    logic [DATA_WIDTH:0]   k_mask;
    assign prod_lo = DATA_WIDTH'(n_q * n_prime);
    assign k_mask  = ((DATA_WIDTH + 1)'(1) << bit_length) - (DATA_WIDTH + 1)'(1);

    // Published results must satisfy the Montgomery identities.
    always_ff @(posedge clk) begin
        if (!reset && valid) begin
            assert (rrm < n_q)
                else $error("montgomery_setup: rrm %0d not below N %0d", rrm, n_q);
            assert ((prod_lo & k_mask[DATA_WIDTH-1:0]) == k_mask[DATA_WIDTH-1:0])
                else $error("montgomery_setup: N*n_prime not -1 mod 2^k");
        end
    end
`endif

endmodule
